// File: rtl/ifetch_seq.sv
// ifetch_seq: instruction fetch sequencer with one outstanding memory
// request, a one-entry skid buffer for Decode stalls, and redirect handling.
//
// Parameters:
//   RESET_PC        first fetch address after reset
//   TIMEOUT_CYCLES  response watchdog limit (only with IFETCH_TIMEOUT_EN)
//
// Optional feature macro: IFETCH_TIMEOUT_EN
//   defined   -> WAIT cycles without a response are counted; on reaching
//                TIMEOUT_CYCLES fetch_err is set (sticky) and pc_f is re-issued
//   undefined -> no counter, fetch_err tied 0, WAIT waits indefinitely
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   redirect, redirect_pc     taken branch/jump from Execute and its target
//   stall_d                   Decode stall (Decode register holds)
//   mem_req_valid/ready       request handshake, mem_addr is the address
//   mem_rsp_valid/data        response (no backpressure)
//   valid_d, instr_d, pc_d, pcplus4_d   Decode stage register
//   fetch_busy                high unless a request is accepted this cycle
//   fetch_err                 sticky response timeout flag
module ifetch_seq #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall_d,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        valid_d,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pcplus4_d,
    output logic        fetch_busy,
    output logic        fetch_err
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state, state_next;
    logic [31:0] pc_f, pc_next, pc_plus4;
    logic        discard, discard_next;
    logic [31:0] skid_data;
    logic        can_load, load_d, load_from_skid, skid_load;
    logic        timeout_hit;

`ifdef IFETCH_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] to_cnt, to_cnt_next;
`endif

    assign pc_plus4      = pc_f + 32'd4;
    assign can_load      = !stall_d || !valid_d;
    assign mem_req_valid = (state == REQ);
    assign mem_addr      = pc_f;
    assign fetch_busy    = !((state == REQ) && mem_req_ready);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next     = state;
        pc_next        = pc_f;
        discard_next   = discard;
        load_d         = 1'b0;
        load_from_skid = 1'b0;
        skid_load      = 1'b0;
        timeout_hit    = 1'b0;
        // any response arriving while discard is set is the stale one
        if (mem_rsp_valid && discard) discard_next = 1'b0;
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (mem_req_ready) begin
                    state_next = WAIT;
                    // the accepted request belongs to the old path
                    if (redirect) discard_next = 1'b1;
                end
            end
            WAIT: begin
                if (redirect) begin
                    if (mem_rsp_valid) state_next = REQ;
                    else               discard_next = 1'b1;
                end else if (mem_rsp_valid) begin
                    if (discard) begin
                        state_next = REQ;
                    end else if (can_load) begin
                        load_d     = 1'b1;
                        pc_next    = pc_plus4;
                        state_next = REQ;
                    end else begin
                        skid_load  = 1'b1;
                        state_next = HOLD;
                    end
                end
`ifdef IFETCH_TIMEOUT_EN
                else if (to_cnt >= TO_LAST) begin
                    timeout_hit  = 1'b1;
                    discard_next = 1'b1;
                    state_next   = REQ;
                end
`endif
            end
            HOLD: begin
                if (redirect) begin
                    state_next = REQ;
                end else if (can_load) begin
                    load_d         = 1'b1;
                    load_from_skid = 1'b1;
                    pc_next        = pc_plus4;
                    state_next     = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
        if (redirect) pc_next = redirect_pc;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_f      <= RESET_PC;
            discard   <= 1'b0;
            skid_data <= '0;
            valid_d   <= 1'b0;
            instr_d   <= NOP;
            pc_d      <= '0;
            pcplus4_d <= '0;
        end else begin
            pc_f    <= pc_next;
            discard <= discard_next;
            if (skid_load)     skid_data <= mem_rsp_data;
            else if (redirect) skid_data <= '0;
            if (redirect) begin
                valid_d <= 1'b0;
                instr_d <= NOP;
            end else if (load_d) begin
                valid_d   <= 1'b1;
                instr_d   <= load_from_skid ? skid_data : mem_rsp_data;
                pc_d      <= pc_f;
                pcplus4_d <= pc_plus4;
            end else if (!stall_d) begin
                valid_d <= 1'b0;
            end
        end
    end

`ifdef IFETCH_TIMEOUT_EN
    always_comb begin
        to_cnt_next = '0;
        if ((state == WAIT) && !mem_rsp_valid)
            to_cnt_next = timeout_hit ? '0 : to_cnt + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt    <= '0;
            fetch_err <= 1'b0;
        end else begin
            to_cnt <= to_cnt_next;
            if (timeout_hit) fetch_err <= 1'b1;
        end
    end
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: doc/ifetch_seq.md
IFETCH_SEQ -- requirements
Module: ifetch_seq

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 16, giving the response watchdog limit in cycles.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port redirect, input, 1 bit: a taken branch or jump from Execute.
REQ-006 The block SHALL have port redirect_pc, input, 32 bits: the target address for redirect.
REQ-007 The block SHALL have port stall_d, input, 1 bit: Decode stall; the Decode register holds while asserted.
REQ-008 The block SHALL have port mem_req_valid, output, 1 bit: instruction memory request valid.
REQ-009 The block SHALL have port mem_req_ready, input, 1 bit: the memory accepts the request this cycle.
REQ-010 The block SHALL have port mem_addr, output, 32 bits: the request address.
REQ-011 The block SHALL have port mem_rsp_valid, input, 1 bit: response data is valid; it carries no backpressure.
REQ-012 The block SHALL have port mem_rsp_data, input, 32 bits: the instruction word.
REQ-013 The block SHALL have outputs valid_d (1 bit), instr_d (32), pc_d (32) and pcplus4_d (32), forming the Decode stage register.
REQ-014 The block SHALL have output fetch_busy, 1 bit, high whenever no request is being accepted this cycle.
REQ-015 The block SHALL have output fetch_err, 1 bit, a sticky timeout flag.

Function
REQ-016 The block SHALL implement FSM states IDLE, REQ, WAIT and HOLD, with at most one outstanding memory request.
REQ-017 IDLE SHALL go to REQ after 1 cycle.
REQ-018 In REQ, mem_req_valid SHALL be 1 and mem_addr SHALL equal pc_f; on mem_req_ready=1 the state SHALL go to WAIT.
REQ-019 In REQ with mem_req_ready=0, mem_addr may change only because of a redirect; the memory side permits address change before acceptance.
REQ-020 In WAIT with mem_rsp_valid=1 and the discard flag clear, if stall_d=0 or valid_d=0 the block SHALL:
- load instr_d=mem_rsp_data, pc_d=pc_f, pcplus4_d=pc_f+4 and valid_d=1;
- set pc_f to pc_f+4 and go to REQ.
REQ-021 Otherwise, in the case of REQ-020, the block SHALL capture the response into a skid register and go to HOLD.
REQ-022 In HOLD, on the first cycle with stall_d=0 the skid contents SHALL move to the Decode register, pc_f SHALL advance by 4 and the state SHALL go to REQ.
REQ-023 With stall_d=1 and valid_d=1 and no redirect, all Decode register outputs SHALL hold their values.
REQ-024 With stall_d=0 and no new instruction loaded, valid_d SHALL go to 0 and pc_d, instr_d and pcplus4_d SHALL hold.
REQ-025 On a redirect, regardless of state or stall_d (redirect has highest priority), the block SHALL:
- clear valid_d and set instr_d to 32'h0000_0013 (NOP) the next cycle;
- set pc_f to redirect_pc;
- drop any skid contents.
REQ-026 A redirect in WAIT, or in REQ with mem_req_ready=1, SHALL set the discard flag; the next response SHALL be dropped and the discard flag cleared, after which the block SHALL go to REQ at the redirected pc_f.
REQ-027 A redirect in HOLD SHALL go to REQ; a redirect in REQ with mem_req_ready=0 SHALL stay in REQ.
REQ-028 A redirect in the same cycle as mem_rsp_valid in WAIT SHALL drop that response and go to REQ.
REQ-029 pc_f+4 SHALL wrap modulo 2^32; 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-030 fetch_busy SHALL equal NOT(state==REQ AND mem_req_ready).

Reset
REQ-031 With rst=0 at a clock edge, the block SHALL set: state=IDLE, pc_f=RESET_PC, valid_d=0, instr_d=32'h0000_0013, pc_d=0, pcplus4_d=0, discard=0, skid cleared, fetch_err=0 and the timeout counter=0.
REQ-032 A reset during WAIT SHALL abandon the in-flight request; the memory side is reset concurrently.

Configuration
REQ-033 With IFETCH_TIMEOUT_EN defined, a counter SHALL increment each WAIT cycle without a response.
REQ-034 With IFETCH_TIMEOUT_EN defined, on reaching TIMEOUT_CYCLES the block SHALL set fetch_err=1 (sticky until reset), set discard and go to REQ re-issuing the same pc_f.
REQ-035 With IFETCH_TIMEOUT_EN undefined, the block SHALL have no counter, fetch_err SHALL be tied 0 and WAIT SHALL wait indefinitely.

Verification
REQ-036 Reset with RESET_PC=32'h100, mem_req_ready=1 and 1-cycle response -> addresses 100, 104, 108; valid_d=1 with pc_d=100 and instr_d equal to the memory word 2 cycles after the first request accept.
REQ-037 stall_d=1 for 3 cycles while a response arrives -> state HOLD, pc_d is unchanged for 3 cycles, the skid word appears in the cycle after stall_d falls, and no response is lost.
REQ-038 redirect with redirect_pc=32'h200 while in WAIT -> the next response is dropped, valid_d=0, the next mem_addr=200, and no stale instruction reaches Decode.
REQ-039 redirect and mem_rsp_valid in the same cycle, with stall_d=1 -> redirect wins, the response is dropped and the next request is issued to redirect_pc.
REQ-040 pc_f=32'hFFFF_FFFC -> the next mem_addr=32'h0000_0000 and pcplus4_d=0.
REQ-041 With IFETCH_TIMEOUT_EN defined and TIMEOUT_CYCLES=4, no response -> fetch_err=1 after 4 WAIT cycles, the same address is re-issued and a late response to the first request is discarded.
